// File: rtl/conv_result_streamer.sv
// Drains the convolution output memory onto a valid/ready stream, hiding the
// synchronous read latency behind a 2-entry buffer. Optional: RESULT_CHECKSUM_EN.
module conv_result_streamer #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   out_count,
    input  logic [ADDR_W-1:0] base_addr,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              busy,
    output logic              done
`ifdef RESULT_CHECKSUM_EN
    ,
    output logic [DATA_W-1:0] checksum
`endif
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        FINISH
    } state_t;

    localparam logic [ADDR_W:0]   CNT_ONE  = 1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;

    state_t            state;
    state_t            state_next;

    logic [ADDR_W:0]   rd_left;
    logic [ADDR_W:0]   tx_left;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_pending;

    logic [DATA_W-1:0] buf_q [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        occupancy;

    logic              start_ok;
    logic              issue;
    logic [1:0]        credit_used;
    logic              buf_empty;
    logic              xfer;
    logic              push;
    logic              pop;

    // Credits count both buffered words and the read still in flight, so the
    // buffer can never be asked to hold a third word.
    always_comb begin
        start_ok    = (state == IDLE) && start;
        credit_used = occupancy + {1'b0, rd_pending};
        issue       = (state == FETCH) && (rd_left != '0) && (credit_used < 2'd2);
        buf_empty   = (occupancy == 2'd0);
    end

    // When the buffer is empty the returning read word is presented straight
    // from the memory port, so the first word appears the cycle it arrives.
    always_comb begin
        m_valid = !buf_empty || rd_pending;
        if (!buf_empty) begin
            m_data = buf_q[rd_ptr];
        end else if (rd_pending) begin
            m_data = mem_rdata;
        end else begin
            m_data = '0;
        end
        xfer   = m_valid && m_ready;
        push   = rd_pending && !(buf_empty && m_ready);
        pop    = xfer && !buf_empty;
        m_last = m_valid && (tx_left == CNT_ONE);
    end

    always_comb begin
        mem_en   = issue;
        mem_addr = rd_addr;
        busy     = (state != IDLE);
        done     = (state == FINISH);
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = (out_count == '0) ? FINISH : FETCH;
                end
            end
            FETCH: begin
                if (issue && (rd_left == CNT_ONE)) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (xfer && (tx_left == CNT_ONE)) begin
                    state_next = FINISH;
                end
            end
            FINISH: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_left    <= '0;
            tx_left    <= '0;
            rd_addr    <= '0;
            rd_pending <= 1'b0;
        end else begin
            rd_pending <= issue;
            if (start_ok) begin
                rd_left <= out_count;
                tx_left <= out_count;
                rd_addr <= base_addr;
            end else begin
                if (issue) begin
                    rd_left <= rd_left - CNT_ONE;
                    rd_addr <= rd_addr + ADDR_ONE;
                end
                if (xfer) begin
                    tx_left <= tx_left - CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                buf_q[i] <= '0;
            end
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            occupancy <= 2'd0;
        end else begin
            if (push) begin
                buf_q[wr_ptr] <= mem_rdata;
                wr_ptr        <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({push, pop})
                2'b10:   occupancy <= occupancy + 2'd1;
                2'b01:   occupancy <= occupancy - 2'd1;
                default: occupancy <= occupancy;
            endcase
        end
    end

`ifdef RESULT_CHECKSUM_EN
    // Running sum of delivered words; holds after done until the next start.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            checksum <= '0;
        end else if (start_ok) begin
            checksum <= '0;
        end else if (xfer) begin
            checksum <= checksum + m_data;
        end
    end
`endif

endmodule
